sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  Initiator side of the 16-bit external SRAM interface. Accepts 32-bit word
//  read/write requests from the ARM MEM stage and performs each as two 16-bit
//  SRAM accesses: low half, then high half. Holds ready low while busy so the
//  pipeline freezes until the access completes.
// PARAMETERS
//  BASE_ADDR    1024  CPU byte address mapped to SRAM word 0
//  WAIT_CYCLES  2     cycles per 16-bit SRAM phase (1..15)
// PORTS
//  clk        input   1   system clock, rising edge
//  rst        input   1   asynchronous, active-low reset (asserted at 0)
//  wr_en      input   1   CPU write request (level, sampled in IDLE)
//  rd_en      input   1   CPU read request (level, sampled in IDLE)
//  address    input   32  CPU byte address, word aligned
//  wdata      input   32  CPU write data
//  rdata      output  32  read data, registered
//  ready      output  1   1 = no access pending / access completing this cycle
//  sram_addr  output  18  SRAM halfword address
//  sram_dq    inout   16  SRAM data bus
//  sram_we_n  output  1   SRAM write strobe, active low
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rdata=0, sram_addr=0, sram_we_n=1,
//   sram_dq=Z, counter=0. Reset mid-access aborts it; no partial write retried.
//  Address map: idx = (address - BASE_ADDR) >> 2, truncated to 17 bits
//   (wraps mod 2^17 words). Low phase sram_addr={idx,0}; high {idx,1}.
//  Request latch: in IDLE, if wr_en|rd_en, latch op, idx, wdata; go LOW.
//   wr_en && rd_en -> write wins. Inputs ignored outside IDLE.
//  FSM: IDLE -> LOW (WAIT_CYCLES) -> HIGH (WAIT_CYCLES) -> DONE (1) -> IDLE.
//   Phase counter counts 0..WAIT_CYCLES-1, advances phase at terminal count.
//  Write phases: sram_dq driven with latched wdata[15:0] (LOW) / [31:16]
//   (HIGH); sram_we_n=0 on all phase cycles except last cycle of each phase
//   (=1 there, so data is held past strobe rising edge). WAIT_CYCLES=1:
//   sram_we_n=0 for the single cycle.
//  Read phases: sram_dq=Z, sram_we_n=1; on last cycle of LOW capture
//   sram_dq into rdata[15:0]; on last cycle of HIGH into rdata[31:16].
//  ready (combinational): 1 in DONE; in IDLE equals ~(wr_en|rd_en); 0 in
//   LOW/HIGH. Request cycle -> ready=0 for 1+2*WAIT_CYCLES cycles, then 1.
//   Latency = 2*WAIT_CYCLES+1 cycles from request to ready=1 (5 at default).
//  rdata valid in DONE, held until next read completes; writes leave rdata.
//  DONE->IDLE unconditionally; a still-asserted request starts a new access
//   the following cycle (CPU must drop request when it sees ready=1).
//  sram_dq driven only in write phases; never driven in IDLE/DONE/reset.
// STRUCTURE
//  Shared package arm_mem_pkg: state enum {IDLE,LOW,HIGH,DONE}, SRAM_AW=18,
//   SRAM_DW=16, default BASE_ADDR. One sub-module: sram_phase_counter
//   (load/clear, terminal-count output, width $clog2(WAIT_CYCLES+1)).
//  Bench uses the existing SRAM behavioural model as responder.
// TESTING
//  Reset: rst=0 mid-write at LOW cycle 1 -> IDLE, sram_we_n=1, dq=Z, rdata=0;
//   memory halfword 0 unchanged at its prior value.
//  Write: wr_en, address=1024, wdata=0xDEADBEEF -> SRAM[0]=0xBEEF,
//   SRAM[1]=0xDEAD; ready=0 exactly 5 cycles, then 1.
//  Read back: rd_en, address=1024 -> rdata=0xDEADBEEF in DONE; ready low 5 cyc.
//  Both requests: wr_en=rd_en=1, address=1032, wdata=0x12345678 -> write done,
//   SRAM[4]=0x5678, SRAM[5]=0x1234, rdata unchanged.
//  Request change mid-access: address 1024 -> 1028 during LOW -> access still
//   hits sram_addr 0/1 only.
//  WAIT_CYCLES=1 build: back-to-back reads 1024,1028 -> ready low 3 cycles each,
//   correct data, sram_dq never driven by controller.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM MEM-stage to external SRAM path.
package arm_mem_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int IDX_W   = SRAM_AW - 1;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    // CPU byte address -> 32-bit word index in SRAM, wrapping mod 2^IDX_W words
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr,
                                                  input logic [31:0] base);
        return IDX_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side request/response bundle between the MEM stage and the SRAM controller.
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output wr_en, rd_en, address, wdata, input rdata, ready);
    modport slave  (input wr_en, rd_en, address, wdata, output rdata, ready);

endinterface

// File: rtl/sram_phase_counter.sv
// Cycle counter for one 16-bit SRAM phase: counts 0..WAIT_CYCLES-1 and wraps.
module sram_phase_counter #(
    parameter  int WAIT_CYCLES = 2,
    localparam int CW          = $clog2(WAIT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_cnt;

    assign o_tc = (r_cnt == CW'(WAIT_CYCLES - 1));

    // Count while enabled; wrap at terminal count so the next phase starts at 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit CPU reads/writes into two 16-bit SRAM accesses (low, then high).
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n
);

    state_t             r_state;
    state_t             w_next;
    logic               r_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               w_req;
    logic               w_phase;
    logic               w_tc;
    logic               w_drive;
    logic               w_ready;
    logic               w_we_n;
    logic [IDX_W-1:0]   w_idx;
    logic [SRAM_DW-1:0] w_dq_out;

    assign w_req   = bus.wr_en | bus.rd_en;
    assign w_phase = (r_state == LOW) || (r_state == HIGH);
    assign w_idx   = word_idx(bus.address, BASE_ADDR);

    sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~w_phase),
        .i_en  (w_phase),
        .o_tc  (w_tc)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state, ready and write strobe
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we_n  = 1'b1;
        w_drive = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~w_req;
                if (w_req) w_next = LOW;
            end
            LOW, HIGH: begin
                w_drive = r_wr;
                // Strobe rises on the last cycle so data is held past the edge;
                // a single-cycle phase has no room for that and strobes throughout.
                if (r_wr) w_we_n = (WAIT_CYCLES > 1) && w_tc;
                if (w_tc) w_next = (r_state == LOW) ? HIGH : DONE;
            end
            DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the request in IDLE, step the halfword address, capture read halves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            sram_addr <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_wr      <= bus.wr_en;
                    r_idx     <= w_idx;
                    r_wdata   <= bus.wdata;
                    sram_addr <= {w_idx, 1'b0};
                end
                LOW: if (w_tc) begin
                    if (!r_wr) r_rdata[15:0] <= sram_dq;
                    sram_addr <= {r_idx, 1'b1};
                end
                HIGH: if (w_tc && !r_wr) r_rdata[31:16] <= sram_dq;
                default: ;
            endcase
        end
    end

    assign w_dq_out  = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
    assign sram_dq   = w_drive ? w_dq_out : {SRAM_DW{1'bz}};
    assign sram_we_n = w_we_n;
    assign bus.ready = w_ready;
    assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Bench: SRAM responder models, vector table of CPU requests, write/read scoreboards.
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    sram_controller_if bus ();
    sram_controller_if bus1 ();

    wire  [15:0] dq;
    wire  [15:0] dq1;
    logic [17:0] sa, sa1;
    logic        we_n, we_n1;
    logic        oe;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sram_addr(sa), .sram_dq(dq), .sram_we_n(we_n));

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sram_addr(sa1), .sram_dq(dq1), .sram_we_n(we_n1));

    // SRAM model for the main instance: samples a write on each clock with strobe low
    logic [15:0] mem [0:255];
    logic [17:0] wlog_a [0:63];
    logic [15:0] wlog_d [0:63];
    int          wcnt = 0;
    assign dq = (oe && we_n) ? mem[sa[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!we_n) begin
            mem[sa[7:0]]       <= dq;
            wlog_a[wcnt[5:0]]  <= sa;
            wlog_d[wcnt[5:0]]  <= dq;
            wcnt               <= wcnt + 1;
        end
    end

    // Read-only responder for the single-wait instance: data is a pattern of the address
    function automatic logic [15:0] f1(input logic [17:0] a);
        return {~a[7:0], a[7:0]};
    endfunction
    assign dq1 = we_n1 ? f1(sa1) : 16'hzzzz;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        string       nm;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chg;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    wr_t         exp_wq[$];
    logic [31:0] exp_rq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          we1_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] idx_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'd1024) >> 2;
        return off[16:0];
    endfunction

    // Issue one request on the main instance; called right at a falling edge
    task automatic do_req(input vec_t v);
        int          lat;
        int          w0;
        int          nw;
        logic [16:0] idx;
        logic [31:0] got;
        wr_t         e;
        idx = idx_of(v.addr);
        w0  = wcnt;
        if (v.wr) begin
            exp_wq.push_back('{{idx, 1'b0}, v.wd[15:0]});
            exp_wq.push_back('{{idx, 1'b1}, v.wd[31:16]});
        end
        exp_rq.push_back(v.exp_rd);
        bus.wr_en   = v.wr;
        bus.rd_en   = v.rd;
        bus.address = v.addr;
        bus.wdata   = v.wd;
        oe          = v.rd & ~v.wr;
        lat = 0;
        #1;
        while (bus.ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
            #1;
            if (v.chg && lat == 1) begin
                bus.address = v.addr + 32'd4;
                bus.wdata   = ~v.wd;
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        oe        = 1'b0;
        check({v.nm, "_lat"}, 64'(lat), 64'(v.exp_lat));
        got = exp_rq.pop_front();
        check({v.nm, "_rdata"}, 64'(bus.rdata), 64'(got));
        @(negedge clk);
        nw = wcnt - w0;
        check({v.nm, "_nwr"}, 64'(nw), 64'(v.wr ? 2 : 0));
        for (int k = 0; k < nw && exp_wq.size() > 0; k++) begin
            e = exp_wq.pop_front();
            check({v.nm, "_waddr"}, 64'(wlog_a[6'(w0 + k)]), 64'(e.a));
            check({v.nm, "_wdata"}, 64'(wlog_d[6'(w0 + k)]), 64'(e.d));
        end
        exp_wq.delete();
    endtask

    // Read on the single-wait instance; request left asserted for back-to-back use
    task automatic do_rd1(input string nm, input logic [31:0] addr);
        int          lat;
        logic [16:0] idx;
        idx = idx_of(addr);
        exp_rq.push_back({f1({idx, 1'b1}), f1({idx, 1'b0})});
        bus1.rd_en   = 1'b1;
        bus1.address = addr;
        lat = 0;
        #1;
        if (we_n1 !== 1'b1) we1_bad++;
        while (bus1.ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
            #1;
            if (we_n1 !== 1'b1) we1_bad++;
        end
        check({nm, "_lat"}, 64'(lat), 64'd3);
        check({nm, "_rdata"}, 64'(bus1.rdata), 64'(exp_rq.pop_front()));
    endtask

    vec_t vecs [9];
    vec_t v;
    int   w0;

    initial begin
        vecs[0] = '{"wr_1024",   1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h00000000, 5};
        vecs[1] = '{"rd_1024",   1'b0, 1'b1, 32'd1024, 32'h0,        1'b0, 32'hDEADBEEF, 5};
        vecs[2] = '{"both_1032", 1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, 32'hDEADBEEF, 5};
        vecs[3] = '{"rd_1032",   1'b0, 1'b1, 32'd1032, 32'h0,        1'b0, 32'h12345678, 5};
        vecs[4] = '{"wr_wrap",   1'b1, 1'b0, 32'd1020, 32'h0A0B0C0D, 1'b0, 32'h12345678, 5};
        vecs[5] = '{"rd_wrap",   1'b0, 1'b1, 32'd1020, 32'h0,        1'b0, 32'h0A0B0C0D, 5};
        vecs[6] = '{"rd_1024b",  1'b0, 1'b1, 32'd1024, 32'h0,        1'b0, 32'hDEADBEEF, 5};
        vecs[7] = '{"wr_chg",    1'b1, 1'b0, 32'd1024, 32'h55AA33CC, 1'b1, 32'hDEADBEEF, 5};
        vecs[8] = '{"rd_chg",    1'b0, 1'b1, 32'd1024, 32'h0,        1'b0, 32'h55AA33CC, 5};

        rst = 1'b0;
        oe  = 1'b0;
        bus.wr_en = 1'b0;  bus.rd_en = 1'b0;  bus.address = '0;  bus.wdata = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.address = '0; bus1.wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready",  64'(bus.ready), 64'd1);
        check("rst_we_n",   64'(we_n),      64'd1);
        check("rst_rdata",  64'(bus.rdata), 64'd0);
        check("rst_addr",   64'(sa),        64'd0);
        check("rst_ready1", 64'(bus1.ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) do_req(vecs[i]);

        // Reset during the first LOW cycle of a write: nothing may reach SRAM
        w0 = wcnt;
        bus.wr_en   = 1'b1;
        bus.address = 32'd1024;
        bus.wdata   = 32'h0BAD0BAD;
        @(negedge clk);
        check("mid_we_n", 64'(we_n), 64'd0);
        rst = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        check("arst_we_n",  64'(we_n),      64'd1);
        check("arst_rdata", 64'(bus.rdata), 64'd0);
        check("arst_addr",  64'(sa),        64'd0);
        check("arst_ready", 64'(bus.ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("arst_nowr", 64'(wcnt - w0), 64'd0);
        @(negedge clk);
        v = '{"rd_after_rst", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'h55AA33CC, 5};
        do_req(v);

        // Single-wait build: back-to-back reads
        do_rd1("w1_rd_1024", 32'd1024);
        @(negedge clk);
        do_rd1("w1_rd_1028", 32'd1028);
        bus1.rd_en = 1'b0;
        @(negedge clk);
        check("w1_we_n_high", 64'(we1_bad), 64'd0);
        check("rq_empty", 64'(exp_rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
